// File: rtl/count_seq_pkg.sv
// Shared types for the counter sequencing controller.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/conv_req_if.sv
// Count-change detector feeding the BCD converter over a valid/ready handshake.
module conv_req_if #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             conv_ready,
    output logic             conv_valid,
    output logic [WIDTH-1:0] conv_data
);

    logic [WIDTH-1:0] last_sent;

    // Intermediate counts seen while a request is pending are dropped; only
    // the value present at the next issue is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_valid <= 1'b0;
            conv_data  <= '0;
            last_sent  <= '0;
        end else if (!conv_valid) begin
            if (count != last_sent) begin
                conv_valid <= 1'b1;
                conv_data  <= count;
            end
        end else if (conv_ready) begin
            last_sent  <= conv_data;
            conv_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the loadable counter: load, paced increment, wrap/one-shot
// termination, plus the BCD conversion request path.
import count_seq_pkg::*;

module count_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] limit,
    output logic             cnt_en,
    output logic             cnt_ld,
    output logic [WIDTH-1:0] cnt_ld_val,
    input  logic [WIDTH-1:0] count,
    output logic             conv_valid,
    output logic [WIDTH-1:0] conv_data,
    input  logic             conv_ready,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start, counter untouched
    // LOAD  | one cycle of cnt_ld with the captured preload
    // RUN   | prescaler pacing; increment or terminal action on each tick
    // HALT  | one-shot finished, counter parked at limit

    localparam int DIV_W = $clog2(DIV + 1);

    state_t           state;
    logic [WIDTH-1:0] cap_v;
    logic [WIDTH-1:0] cap_limit;
    logic             cap_mode;
    logic [DIV_W-1:0] presc;
    logic             tick;
    logic             at_limit;

    assign tick       = (state == RUN) && (presc == DIV_W'(DIV - 1));
    assign at_limit   = (count == cap_limit);
    assign cnt_ld_val = cap_v;

    // The increment and done must land in the tick cycle itself so the counter
    // is already updated by the next tick, even with DIV = 1; stop masks both.
    assign cnt_en = tick && !at_limit && !stop;
    assign done   = tick && at_limit && (cap_mode == MODE_ONESHOT) && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_v     <= '0;
            cap_limit <= '0;
            cap_mode  <= MODE_WRAP;
            presc     <= '0;
            cnt_ld    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (start) begin
                        cap_v     <= v;
                        cap_limit <= limit;
                        cap_mode  <= mode;
                        cnt_ld    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    cnt_ld <= 1'b0;
                    presc  <= '0;
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (tick && at_limit) begin
                        if (cap_mode == MODE_WRAP) begin
                            cnt_ld <= 1'b1;
                            state  <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= HALT;
                        end
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    conv_req_if #(.WIDTH(WIDTH)) u_conv_req (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .conv_ready (conv_ready),
        .conv_valid (conv_valid),
        .conv_data  (conv_data)
    );

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench: two controllers (DIV=4 and DIV=1), each driving a counter model.
module tb_count_seq_ctrl;
    import count_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1, stop, mode, conv_ready;
    logic [7:0] v, limit;

    logic       cnt_en, cnt_ld, conv_valid, busy, done;
    logic [7:0] cnt_ld_val, conv_data, count;
    logic       cnt_en1, cnt_ld1, conv_valid1, busy1, done1;
    logic [7:0] cnt_ld_val1, conv_data1, count1;

    int n_chk  = 0;
    int n_fail = 0;
    int done1_cnt = 0;
    int ld1_seen  = 0;

    logic [7:0] exp_ld[$], exp_en[$], exp_done[$], exp_conv[$];
    logic [7:0] exp1_ld[$], exp1_en[$];

    always #5 clk = ~clk;

    count_seq_ctrl #(.WIDTH(8), .DIV(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .v(v), .limit(limit), .cnt_en(cnt_en), .cnt_ld(cnt_ld),
        .cnt_ld_val(cnt_ld_val), .count(count), .conv_valid(conv_valid),
        .conv_data(conv_data), .conv_ready(conv_ready), .busy(busy), .done(done)
    );

    count_seq_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .mode(mode),
        .v(v), .limit(limit), .cnt_en(cnt_en1), .cnt_ld(cnt_ld1),
        .cnt_ld_val(cnt_ld_val1), .count(count1), .conv_valid(conv_valid1),
        .conv_data(conv_data1), .conv_ready(1'b1), .busy(busy1), .done(done1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            count1 <= '0;
        end else begin
            if (cnt_ld)       count <= cnt_ld_val;
            else if (cnt_en)  count <= count + 8'd1;
            if (cnt_ld1)      count1 <= cnt_ld_val1;
            else if (cnt_en1) count1 <= count1 + 8'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic unexp(input string name, input int act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0d, expected none", name, act);
    endtask

    // Monitor: pops the expected value whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (cnt_ld) begin
                if (exp_ld.size() == 0) unexp("ld", cnt_ld_val);
                else chk("ld", cnt_ld_val, exp_ld.pop_front());
            end
            if (cnt_en) begin
                if (exp_en.size() == 0) unexp("en", count);
                else chk("en", count, exp_en.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) unexp("done", count);
                else chk("done", count, exp_done.pop_front());
            end
            if (conv_valid && conv_ready) begin
                if (exp_conv.size() == 0) unexp("conv", conv_data);
                else chk("conv", conv_data, exp_conv.pop_front());
            end
            if (cnt_ld1) begin
                ld1_seen++;
                if (exp1_ld.size() == 0) unexp("ld1", cnt_ld_val1);
                else chk("ld1", cnt_ld_val1, exp1_ld.pop_front());
            end
            if (cnt_en1) begin
                if (exp1_en.size() == 0) unexp("en1", count1);
                else chk("en1", count1, exp1_en.pop_front());
            end
            if (done1) done1_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] v_i, input logic [7:0] l_i, input logic m_i);
        v = v_i; limit = l_i; mode = m_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_state(input state_t s, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk); #1;
            if (u_dut.state == s) found = 1'b1;
        end
        if (!found) unexp({name, "_timeout"}, int'(u_dut.state));
        @(posedge clk); #1;
    endtask

    task automatic drained(input string name);
        chk({name, "_ld_left"},   exp_ld.size(),   0);
        chk({name, "_en_left"},   exp_en.size(),   0);
        chk({name, "_done_left"}, exp_done.size(), 0);
        chk({name, "_conv_left"}, exp_conv.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        rst = 1'b1; start = 0; start1 = 0; stop = 0; mode = 0;
        v = 0; limit = 0; conv_ready = 1'b1;
        #2;
        chk("reset_outs", int'({cnt_en, cnt_ld, cnt_ld_val, conv_valid, conv_data, busy, done}), 0);
        chk("reset_state", int'(u_dut.state), int'(IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cycles(2);

        // Basic one-shot, DIV=4
        exp_ld = '{8'd3}; exp_en = '{8'd3, 8'd4, 8'd5}; exp_done = '{8'd6};
        exp_conv = '{8'd3, 8'd4, 8'd5, 8'd6};
        pulse_start(8'd3, 8'd6, MODE_ONESHOT);
        cycles(8);
        chk("t1_busy_run", busy, 1);
        wait_state(HALT, "t1_halt");
        chk("t1_busy_halt", busy, 0);
        chk("t1_count", count, 6);
        cycles(3);
        drained("t1");
        do_stop();
        chk("t1_idle", int'(u_dut.state), int'(IDLE));

        // Wrap through 255 on the DIV=1 instance
        exp1_ld = '{8'd250, 8'd250};
        exp1_en = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
        v = 8'd250; limit = 8'd2; mode = MODE_WRAP; start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk); #1;
            if (ld1_seen == 2) hit = 1'b1;
        end
        if (!hit) unexp("t2_reload_timeout", ld1_seen);
        @(posedge clk); #1;
        do_stop();
        cycles(5);
        chk("t2_done_pulses", done1_cnt, 0);
        chk("t2_ld_left", exp1_ld.size(), 0);
        chk("t2_en_left", exp1_en.size(), 0);
        chk("t2_idle", int'(u_dut1.state), int'(IDLE));
        chk("t2_count", count1, 250);
        chk("t2_conv_settled", int'({conv_valid1, conv_data1}), 250);

        // Backpressure: 4 is coalesced away
        exp_ld = '{8'd3}; exp_en = '{8'd3, 8'd4, 8'd5}; exp_done = '{8'd6};
        exp_conv = '{8'd3, 8'd5, 8'd6};
        conv_ready = 1'b0;
        pulse_start(8'd3, 8'd6, MODE_ONESHOT);
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk); #1;
            if (count == 8'd5) hit = 1'b1;
        end
        if (!hit) unexp("t4_count5_timeout", count);
        chk("t4_valid_held", conv_valid, 1);
        chk("t4_data_held", conv_data, 3);
        @(posedge clk); #1 conv_ready = 1'b1;
        wait_state(HALT, "t4_halt");
        cycles(4);
        drained("t4");
        do_stop();

        // Stop coinciding with a tick at count 4
        exp_ld = '{8'd2}; exp_en = '{8'd2, 8'd3}; exp_conv = '{8'd2, 8'd3, 8'd4};
        pulse_start(8'd2, 8'd9, MODE_WRAP);
        cycles(12);
        stop = 1'b1;
        @(negedge clk);
        chk("t3_en_masked", cnt_en, 0);
        chk("t3_count_at_stop", count, 4);
        @(posedge clk); #1 stop = 1'b0;
        chk("t3_idle", int'(u_dut.state), int'(IDLE));
        chk("t3_busy", busy, 0);
        cycles(10);
        chk("t3_count_frozen", count, 4);
        drained("t3");

        // v == limit: done on the first tick, no increments
        exp_ld = '{8'd7}; exp_done = '{8'd7}; exp_conv = '{8'd7};
        pulse_start(8'd7, 8'd7, MODE_ONESHOT);
        wait_state(HALT, "t6_halt");
        chk("t6_busy", busy, 0);
        chk("t6_count", count, 7);
        cycles(3);
        drained("t6");
        do_stop();

        // Asynchronous reset mid-run
        exp_ld = '{8'd1}; exp_en = '{8'd1, 8'd2}; exp_conv = '{8'd1, 8'd2};
        pulse_start(8'd1, 8'd200, MODE_WRAP);
        cycles(10);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_outs", int'({cnt_en, cnt_ld, cnt_ld_val, conv_valid, conv_data, busy, done}), 0);
        chk("t5_async_state", int'(u_dut.state), int'(IDLE));
        @(posedge clk); #1 rst = 1'b0;
        cycles(5);
        chk("t5_no_req_at_zero", conv_valid, 0);
        chk("t5_busy", busy, 0);
        drained("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Sequencing controller for the team's loadable 8-bit counter and its binary-to-BCD display path.
- Starts, paces, reloads and terminates a count run between a preload value `v` and a limit `limit`, using a built-in prescaler.
- Feeds each new count value to a multi-cycle BCD converter over a valid/ready handshake.
- Sits between the top-level controls (start/stop) and the counter/converter pair.

Parameters:
- WIDTH, 8, counter and data width in bits.
- DIV, 4, prescaler ratio: one count step per DIV cycles in RUN; legal range ≥1.
- DIV_W, $clog2(DIV+1), prescaler register width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; captures v, limit and mode.
- stop  in  1  abort a run; returns to IDLE.
- mode  in  1  0 = wrap (reload v at limit), 1 = one-shot (halt at limit).
- v  in  WIDTH  preload value.
- limit  in  WIDTH  terminal count.
- cnt_en  out  1  increment enable to the counter.
- cnt_ld  out  1  synchronous load strobe to the counter.
- cnt_ld_val  out  WIDTH  load value; equals the captured v.
- count  in  WIDTH  registered counter output; updates one cycle after cnt_en or cnt_ld.
- conv_valid  out  1  BCD conversion request.
- conv_data  out  WIDTH  value to convert.
- conv_ready  in  1  converter accepts the request.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse when a one-shot run reaches its limit.

Behaviour:
- Reset: state = IDLE and all outputs 0. This covers cnt_en, cnt_ld, cnt_ld_val, conv_valid, conv_data, busy and done. Captured registers, the prescaler and last_sent are also 0.
- Reset is asynchronous. Asserting rst mid-run aborts immediately, with no done pulse and no pending request kept.
- States are IDLE, LOAD, RUN and HALT. Encode them as an enum in the package.
- IDLE
  - cnt_en = 0 and cnt_ld = 0.
  - When start = 1: capture v, limit and mode, then go to LOAD.
- LOAD
  - Exactly one cycle. Drive cnt_ld = 1 with cnt_ld_val = captured v.
  - Clear the prescaler to 0, then go to RUN.
- RUN
  - The prescaler counts 0 to DIV-1 and wraps. tick = (presc == DIV-1). With DIV = 1, tick is high every cycle.
  - On a tick, compare count with the captured limit:
    - Not equal: cnt_en = 1 for that cycle only.
    - Equal, mode 0: go to LOAD (cnt_en stays 0).
    - Equal, mode 1: go to HALT and pulse done the same cycle.
  - cnt_en is only ever asserted on a tick in RUN.
- HALT
  - Counter holds at limit.
  - start = 1 recaptures inputs and goes to LOAD.
  - stop = 1 goes to IDLE.
- Priority within a cycle: stop > terminal-count action > tick increment. A start in LOAD or RUN is ignored.
- stop in LOAD/RUN/HALT goes to IDLE next cycle; cnt_en and cnt_ld are 0 from that cycle.
- Wrap semantics: the limit is compared for equality only.
  - If v > limit in mode 0, the counter wraps modulo 2^WIDTH before reaching limit. This is legal.
  - If v == limit, the terminal action fires on the first tick.
- Conversion handshake
  - This logic is independent of the FSM state and active whenever out of reset.
  - When conv_valid = 0 and count != last_sent: raise conv_valid next cycle with conv_data = count.
  - While conv_valid = 1, hold conv_data stable until conv_ready = 1.
  - On the valid & ready cycle: last_sent ← conv_data and conv_valid drops next cycle.
  - Values that change while a request is pending are coalesced: only the latest count at the next issue is sent.
  - After reset, last_sent = 0, so a count of 0 generates no request.
- busy = (state == LOAD || state == RUN), registered.

Decomposition:
- Package count_seq_pkg holds the state_t enum (IDLE, LOAD, RUN, HALT) and the mode encodings (MODE_WRAP = 0, MODE_ONESHOT = 1).
- Sub-module conv_req_if contains the count-change detector and the valid/ready request register. It is parameterised on WIDTH.
- The FSM and prescaler stay in count_seq_ctrl.

Test Plan:
- Basic one-shot (rst pulse, DIV = 4, v = 3, limit = 6, mode = 1, start) → cnt_ld in cycle 1 after start with cnt_ld_val = 3. Three cnt_en pulses, one every 4 cycles, take count to 6. done pulses on the next tick, then HALT with busy = 0.
- Wrap mode (v = 250, limit = 2, mode = 0, DIV = 1) → count runs 250…255, 0, 1, 2, then LOAD reasserts cnt_ld with value 250. done never pulses.
- Stop mid-run (assert stop together with a tick, count = 4, limit = 9) → no cnt_en that cycle, IDLE next cycle, count frozen at 4.
- Handshake backpressure (conv_ready = 0 for 10 cycles while count goes 3 → 4 → 5) → conv_valid stays high with conv_data = 3. After ready, 5 is sent next and 4 is never sent.
- Async reset in RUN (rst asserted mid-cycle) → all outputs 0 immediately without waiting for a clock edge, and state = IDLE.
- Edge case v == limit = 7, mode = 1 → LOAD, then done on the first tick, with zero cnt_en pulses.
